// File: rtl/gray_conv_arbiter.sv
// -----------------------------------------------------------------------------
// gray_conv_arbiter
//
// Shares one binary-to-Gray conversion datapath between NUM_REQ requesters.
// A round-robin arbiter picks one valid requester per cycle, converts its word
// and stores the result, tagged with the requester index, in a single
// registered output stage with a valid/ready handshake.
//
// Optional feature (macro GRAY_ARB_G2B_EN):
//   Adds input req_dir. A requester with req_dir[i] = 1 gets its word
//   Gray-to-binary converted instead. Without the macro every word is
//   binary-to-Gray converted and req_dir does not exist.
//
// Ports:
//   clk        in   1              rising-edge clock
//   rst        in   1              asynchronous, active-high reset
//   req_valid  in   NUM_REQ        per-requester valid
//   req_data   in   NUM_REQ*WIDTH  packed words, requester i at [i*WIDTH +: WIDTH]
//   req_dir    in   NUM_REQ        per-requester direction (GRAY_ARB_G2B_EN only)
//   req_ready  out  NUM_REQ        one-hot or zero grant
//   out_valid  out  1              output register holds a word
//   out_data   out  WIDTH          converted word
//   out_id     out  ID_W           index of the requester that produced out_data
//   out_ready  in   1              consumer accepts the output word
// -----------------------------------------------------------------------------
module gray_conv_arbiter #(
    parameter int WIDTH   = 4,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
`ifdef GRAY_ARB_G2B_EN
    input  logic [NUM_REQ-1:0]       req_dir,
`endif
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [ID_W-1:0]          out_id,
    input  logic                     out_ready
);

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

`ifdef GRAY_ARB_G2B_EN
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction
`endif

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  winner;
    logic             found;
    logic             accept;
    logic             grant;
    logic [WIDTH-1:0] win_word;
    logic [WIDTH-1:0] conv_word;
    logic [ID_W-1:0]  next_ptr;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    // A new word fits when the register is empty or is being drained now.
    // Reset suppresses grants so nothing is handshaken while rst is high.
    assign accept = !out_valid || out_ready;
    assign grant  = accept && found && !rst;

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign win_word = req_data[int'(winner)*WIDTH +: WIDTH];

`ifdef GRAY_ARB_G2B_EN
    assign conv_word = req_dir[winner] ? gray2bin(win_word) : bin2gray(win_word);
`else
    assign conv_word = bin2gray(win_word);
`endif

    assign next_ptr = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            rr_ptr    <= '0;
        end else if (grant) begin
            out_valid <= 1'b1;
            out_data  <= conv_word;
            out_id    <= winner;
            rr_ptr    <= next_ptr;
        end else if (out_ready) begin
            // Drained with nothing to replace it: data and id keep last values.
            out_valid <= 1'b0;
        end
    end

endmodule
